// File: rtl/cpu_defs.sv
// Shared core definitions: datapath width and divide-sequencer state encodings.
package cpu_defs;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned RES_W  = 2 * DATA_W;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/div_issue.sv
// EX-stage divide sequencer: launches the iterative divider, stalls EX, holds HI/LO for EX/MEM.
// Optional build macro DIV_FASTPATH_EN resolves trivial unsigned divides without the divider.
module div_issue
  import cpu_defs::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              div_req_i,
  input  logic              div_signed_i,
  input  logic [DATA_W-1:0] opa_i,
  input  logic [DATA_W-1:0] opb_i,
  input  logic              flush_i,
  input  logic              ex_adv_i,
  input  logic [RES_W-1:0]  div_result_i,
  input  logic              div_ready_i,
  output logic              div_start_o,
  output logic              div_signed_o,
  output logic [DATA_W-1:0] div_opa_o,
  output logic [DATA_W-1:0] div_opb_o,
  output logic              div_cancel_o,
  output logic              stall_o,
  output logic              whilo_o,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o
);

  div_state_e        r_state;
  logic              w_accept;
  logic              w_abort;
  logic              w_fast;
  logic [DATA_W-1:0] w_fast_hi;

  assign w_accept = div_req_i & ~flush_i;
  // A request vanishing mid-divide means EX lost the instruction, same as a flush.
  assign w_abort  = flush_i | ~div_req_i;

`ifdef DIV_FASTPATH_EN
  // Unsigned x/0 and x/y with x<y have a known result; skip the divider entirely.
  assign w_fast    = ~div_signed_i & ((opb_i == '0) | (opa_i < opb_i));
  assign w_fast_hi = (opb_i == '0) ? '0 : opa_i;
`else
  assign w_fast    = 1'b0;
  assign w_fast_hi = '0;
`endif

  // Pipeline stall and divider cancel react in the same cycle.
  always_comb begin
    stall_o      = 1'b0;
    div_cancel_o = 1'b0;
    case (r_state)
      DIV_IDLE: stall_o = w_accept & ~w_fast;
      DIV_BUSY: begin
        stall_o      = 1'b1;
        div_cancel_o = w_abort;
      end
      default: stall_o = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= DIV_IDLE;
      div_start_o  <= 1'b0;
      div_signed_o <= 1'b0;
      div_opa_o    <= '0;
      div_opb_o    <= '0;
      whilo_o      <= 1'b0;
      hi_o         <= '0;
      lo_o         <= '0;
    end else begin
      case (r_state)
        DIV_IDLE: begin
          if (flush_i) begin
            hi_o <= '0;
            lo_o <= '0;
          end else if (div_req_i) begin
            div_opa_o    <= opa_i;
            div_opb_o    <= opb_i;
            div_signed_o <= div_signed_i;
            if (w_fast) begin
              hi_o    <= w_fast_hi;
              lo_o    <= '0;
              whilo_o <= 1'b1;
              r_state <= DIV_DONE;
            end else begin
              div_start_o <= 1'b1;
              r_state     <= DIV_BUSY;
            end
          end
        end
        DIV_BUSY: begin
          // Abort beats a simultaneous ready; the divider's answer is dropped.
          if (w_abort) begin
            div_start_o <= 1'b0;
            hi_o        <= '0;
            lo_o        <= '0;
            r_state     <= DIV_IDLE;
          end else if (div_ready_i) begin
            hi_o        <= div_result_i[RES_W-1:DATA_W];
            lo_o        <= div_result_i[DATA_W-1:0];
            div_start_o <= 1'b0;
            whilo_o     <= 1'b1;
            r_state     <= DIV_DONE;
          end
        end
        DIV_DONE: begin
          if (flush_i) begin
            hi_o    <= '0;
            lo_o    <= '0;
            whilo_o <= 1'b0;
            r_state <= DIV_IDLE;
          end else if (ex_adv_i) begin
            whilo_o <= 1'b0;
            r_state <= DIV_IDLE;
          end
        end
        default: begin
          div_start_o <= 1'b0;
          whilo_o     <= 1'b0;
          r_state     <= DIV_IDLE;
        end
      endcase
    end
  end

endmodule
